// File: rtl/heard_sink_pkg.sv
// heard_pkg: shared message, counter and checker-state types for the heard sink
package heard_pkg;
  localparam int HEARD_DATA_W = 32;
  typedef logic [7:0] seq_t;
  typedef logic [15:0] cnt_t;
  typedef struct packed {
    logic [HEARD_DATA_W-1:0] v;
    seq_t seqno;
    seq_t writeCount;
    seq_t readCount;
  } heard_msg_t;
  typedef enum logic {FIRST, RUN} chk_state_t;
endpackage

// File: rtl/heard_sink_if.sv
// heard_sink_if: heard input stream, drained output stream and status counters
interface heard_sink_if #(parameter int DATA_W = 32, parameter int CNT_W = 16);
  logic              heard__ENA;
  logic              heard__RDY;
  logic [DATA_W-1:0] heard_v;
  logic [7:0]        heard_seqno;
  logic [7:0]        heard_writeCount;
  logic [7:0]        heard_readCount;
  logic              out__ENA;
  logic              out__RDY;
  logic [DATA_W-1:0] out_v;
  logic [7:0]        out_seqno;
  logic [7:0]        out_readCount;
  logic [CNT_W-1:0]  msg_count;
  logic [CNT_W-1:0]  gap_count;
  logic [CNT_W-1:0]  dup_count;
  logic [CNT_W-1:0]  wc_err_count;
  modport slave (
    input  heard__ENA, heard_v, heard_seqno, heard_writeCount, heard_readCount, out__RDY,
    output heard__RDY, out__ENA, out_v, out_seqno, out_readCount,
    output msg_count, gap_count, dup_count, wc_err_count
  );
  modport master (
    output heard__ENA, heard_v, heard_seqno, heard_writeCount, heard_readCount, out__RDY,
    input  heard__RDY, out__ENA, out_v, out_seqno, out_readCount,
    input  msg_count, gap_count, dup_count, wc_err_count
  );
endinterface

// File: rtl/heard_sink_fifo.sv
// heard_fifo: DEPTH-entry circular buffer of heard messages, head read straight from storage
module heard_fifo import heard_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       push_i,
  input  logic       pop_i,
  input  heard_msg_t din_i,
  output heard_msg_t dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  heard_msg_t  mem_q [DEPTH];
  // Advance each pointer on its own handshake; the extra MSB separates full from empty
  always_comb begin
    wr_d = push_i ? wr_q + 1'b1 : wr_q;
    rd_d = pop_i ? rd_q + 1'b1 : rd_q;
  end
  // Pointer registers, cleared on reset so stored entries are simply discarded
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // Storage needs no reset; it is only observed while non-empty
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
endmodule

// File: rtl/heard_sink.sv
// heard_sink: buffers heard messages, checks seqno/writeCount continuity, keeps saturating error counters.
// Optional macro HEARD_SINK_DISPLAY_EN prints a trace line for every errored accept.
module heard_sink import heard_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input logic CLK,
  input logic nRST,
  heard_sink_if.slave bus
);
  heard_msg_t       head;
  logic             full, empty, acc, pop, dup, gap, wce;
  chk_state_t       state_q, state_d;
  seq_t             exp_seq_q, exp_seq_d, exp_wc_q, exp_wc_d;
  logic [CNT_W-1:0] msg_q, msg_d, gap_q, gap_d, dup_q, dup_d, wce_q, wce_d;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  assign acc = bus.heard__ENA && !full;
  assign pop = bus.out__RDY && !empty;

  heard_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK(CLK), .nRST(nRST), .push_i(acc), .pop_i(pop),
    .din_i('{v: bus.heard_v, seqno: bus.heard_seqno, writeCount: bus.heard_writeCount, readCount: bus.heard_readCount}),
    .dout_o(head), .full_o(full), .empty_o(empty)
  );

  // Classify the incoming message against the expectations, then resynchronise to it on accept
  always_comb begin
    dup       = state_q == RUN && bus.heard_seqno == seq_t'(exp_seq_q - 8'd1);
    gap       = state_q == RUN && bus.heard_seqno != exp_seq_q && !dup;
    wce       = state_q == RUN && bus.heard_writeCount != exp_wc_q;
    state_d   = acc ? RUN : state_q;
    exp_seq_d = acc ? seq_t'(bus.heard_seqno + 8'd1) : exp_seq_q;
    exp_wc_d  = acc ? seq_t'(bus.heard_writeCount + 8'd1) : exp_wc_q;
    msg_d     = sat(msg_q, acc);
    gap_d     = sat(gap_q, acc && gap);
    dup_d     = sat(dup_q, acc && dup);
    wce_d     = sat(wce_q, acc && wce);
  end

  // Checker state and counters; expectations are don't-care until the first accept
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FIRST;
      msg_q   <= '0;
      gap_q   <= '0;
      dup_q   <= '0;
      wce_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      gap_q   <= gap_d;
      dup_q   <= dup_d;
      wce_q   <= wce_d;
    end
    exp_seq_q <= exp_seq_d;
    exp_wc_q  <= exp_wc_d;
  end

`ifdef HEARD_SINK_DISPLAY_EN
  // Trace errored accepts with the expectations in force before this message
  always_ff @(posedge CLK) begin
    if (nRST && acc && (gap || dup || wce))
      $display("HEARDSINK seqno %x exp %x wc %x expwc %x",
               bus.heard_seqno, exp_seq_q, bus.heard_writeCount, exp_wc_q);
  end
`endif

  assign bus.heard__RDY    = !full;
  assign bus.out__ENA      = !empty;
  assign bus.out_v         = head.v;
  assign bus.out_seqno     = head.seqno;
  assign bus.out_readCount = head.readCount;
  assign bus.msg_count     = msg_q;
  assign bus.gap_count     = gap_q;
  assign bus.dup_count     = dup_q;
  assign bus.wc_err_count  = wce_q;
endmodule

// File: tb/tb_heard_sink.sv
// tb_heard_sink: directed checks of buffering, backpressure, continuity checking and reset
module tb_heard_sink;
  logic CLK = 1'b0;
  logic nRST;
  int   n_chk = 0;
  int   n_fail = 0;

  heard_sink_if #(.DATA_W(32), .CNT_W(16)) bus ();
  heard_sink #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] seq, input logic [7:0] wc);
    bus.heard__ENA       = 1'b1;
    bus.heard_seqno      = seq;
    bus.heard_writeCount = wc;
    bus.heard_readCount  = seq + 8'd7;
    bus.heard_v          = 32'h1000 + 32'(seq);
  endtask

  task automatic send(input logic [7:0] seq, input logic [7:0] wc);
    drive(seq, wc);
    step();
  endtask

  task automatic do_reset();
    bus.heard__ENA = 1'b0;
    nRST = 1'b0;
    step();
    nRST = 1'b1;
  endtask

  task automatic chk_cnt(input string tag, input int m, input int g, input int d, input int w);
    chk({tag, " msg"}, 32'(bus.msg_count), m);
    chk({tag, " gap"}, 32'(bus.gap_count), g);
    chk({tag, " dup"}, 32'(bus.dup_count), d);
    chk({tag, " wc"},  32'(bus.wc_err_count), w);
  endtask

  initial begin
    nRST = 1'b0;
    bus.heard__ENA = 1'b0;
    bus.out__RDY = 1'b0;
    bus.heard_v = '0;
    bus.heard_seqno = '0;
    bus.heard_writeCount = '0;
    bus.heard_readCount = '0;
    step();
    step();
    nRST = 1'b1;
    chk("reset rdy", 32'(bus.heard__RDY), 1);
    chk("reset ena", 32'(bus.out__ENA), 0);
    chk_cnt("reset", 0, 0, 0, 0);

    // Streaming: each message appears one cycle after its push
    bus.out__RDY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(8'(i), 8'(32 + i));
      chk($sformatf("stream ena %0d", i), 32'(bus.out__ENA), 1);
      chk($sformatf("stream seq %0d", i), 32'(bus.out_seqno), i);
      chk($sformatf("stream v %0d", i), bus.out_v, 32'h1000 + i);
      chk($sformatf("stream rc %0d", i), 32'(bus.out_readCount), i + 7);
    end
    bus.heard__ENA = 1'b0;
    step();
    chk("stream drained", 32'(bus.out__ENA), 0);
    chk_cnt("stream", 6, 0, 0, 0);

    // Backpressure: four accepts fill the FIFO, fifth waits for one pop
    bus.out__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp rdy before %0d", i), 32'(bus.heard__RDY), 1);
      send(8'(6 + i), 8'(38 + i));
    end
    chk("bp full rdy", 32'(bus.heard__RDY), 0);
    send(8'd10, 8'd42);
    chk("bp held msg", 32'(bus.msg_count), 10);
    chk("bp held rdy", 32'(bus.heard__RDY), 0);
    bus.out__RDY = 1'b1;
    step();
    bus.out__RDY = 1'b0;
    chk("bp rdy back", 32'(bus.heard__RDY), 1);
    chk("bp head after pop", 32'(bus.out_seqno), 7);
    chk("bp not yet accepted", 32'(bus.msg_count), 10);
    step();
    bus.heard__ENA = 1'b0;
    chk("bp fifth accepted", 32'(bus.msg_count), 11);
    chk("bp full again", 32'(bus.heard__RDY), 0);
    bus.out__RDY = 1'b1;
    for (int k = 7; k <= 10; k++) begin
      chk($sformatf("bp drain seq %0d", k), 32'(bus.out_seqno), k);
      step();
    end
    chk("bp drained", 32'(bus.out__ENA), 0);
    chk_cnt("bp", 11, 0, 0, 0);

    // Gap then duplicate
    do_reset();
    send(8'd10, 8'd50);
    send(8'd11, 8'd51);
    send(8'd13, 8'd52);
    chk("gap one", 32'(bus.gap_count), 1);
    send(8'd13, 8'd53);
    chk("dup one", 32'(bus.dup_count), 1);
    send(8'd14, 8'd54);
    bus.heard__ENA = 1'b0;
    chk_cnt("gapdup", 5, 1, 1, 0);

    // Wrap 255 -> 0 on both counters is not an error
    do_reset();
    send(8'd254, 8'hFE);
    send(8'd255, 8'hFF);
    send(8'd0, 8'h00);
    send(8'd1, 8'h01);
    bus.heard__ENA = 1'b0;
    chk_cnt("wrap", 4, 0, 0, 0);

    // writeCount skip only
    do_reset();
    send(8'd0, 8'd40);
    send(8'd1, 8'd41);
    send(8'd2, 8'd43);
    bus.heard__ENA = 1'b0;
    chk_cnt("wcerr", 3, 0, 0, 1);

    // Gap and writeCount error on the same accept
    send(8'd9, 8'd99);
    bus.heard__ENA = 1'b0;
    chk_cnt("both", 4, 1, 0, 2);

    // Reset with three entries queued
    bus.out__RDY = 1'b0;
    step();
    do_reset();
    send(8'd5, 8'd1);
    send(8'd6, 8'd2);
    send(8'd7, 8'd3);
    bus.heard__ENA = 1'b0;
    chk("mid ena", 32'(bus.out__ENA), 1);
    chk("mid rdy", 32'(bus.heard__RDY), 1);
    do_reset();
    chk("mid reset ena", 32'(bus.out__ENA), 0);
    chk("mid reset rdy", 32'(bus.heard__RDY), 1);
    chk_cnt("mid reset", 0, 0, 0, 0);
    bus.out__RDY = 1'b1;
    send(8'd99, 8'd3);
    bus.heard__ENA = 1'b0;
    chk("after reset head", 32'(bus.out_seqno), 99);
    chk_cnt("after reset", 1, 0, 0, 0);
    step();
    chk("after reset drained", 32'(bus.out__ENA), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/heard_sink.md
Name: heard_sink

Overview:
- Downstream consumer of the Pack block's heard indication stream. Each message carries v, seqno, writeCount and readCount.
- Buffers accepted messages in a small FIFO and forwards them to a drain port under backpressure.
- Checks seqno continuity and writeCount progression at accept time, and keeps saturating error counters for software readout.

Parameters:
- DATA_W, 32: width of the v payload field.
- DEPTH, 4: FIFO entries; must be a power of two, minimum 2.
- CNT_W, 16: width of each status counter.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, synchronous, active-low.
- heard__ENA  input  1  upstream message valid.
- heard__RDY  output  1  sink can accept; equals not-full.
- heard_v  input  DATA_W  payload.
- heard_seqno  input  8  sequence number.
- heard_writeCount  input  8  upstream write counter (already offset by sender).
- heard_readCount  input  8  upstream read counter (already offset by sender).
- out__ENA  output  1  FIFO head valid; equals not-empty.
- out__RDY  input  1  downstream accepts head.
- out_v  output  DATA_W  head payload.
- out_seqno  output  8  head seqno.
- out_readCount  output  8  head readCount.
- msg_count  output  CNT_W  total accepted messages, saturating.
- gap_count  output  CNT_W  seqno jumps, saturating.
- dup_count  output  CNT_W  repeated seqno, saturating.
- wc_err_count  output  CNT_W  writeCount not previous+1, saturating.

Behaviour:
- Reset is synchronous on CLK when nRST=0.
  - Clears FIFO pointers and occupancy; heard__RDY=1, out__ENA=0.
  - All counters 0; checker state FIRST.
  - Data registers need not be reset; out_* data is don't-care while out__ENA=0.
  - Reset mid-operation discards FIFO contents and loses no more than that.
- Accept (push): heard__ENA && heard__RDY on a rising edge. Pop: out__ENA && out__RDY.
- FIFO:
  - Circular buffer, pointers of log2(DEPTH)+1 bits.
  - Full when pointers differ only in MSB; empty when equal.
  - No combinational bypass. A push into an empty FIFO raises out__ENA in the next cycle (latency 1).
  - Push and pop in the same cycle are allowed when neither full nor empty; occupancy is unchanged.
  - When full, heard__RDY=0 even if a pop occurs that cycle. This keeps heard__RDY purely registered-state driven.
  - Output fields come from the head entry: a registered read, with no mux from the input.
- Checker state machine (advances only on accept):
  - FIRST: on accept, latch exp_seq=seqno+1 and exp_wc=writeCount+1 (mod 256), go to RUN; no error counted.
  - RUN, seqno check:
    - seqno==exp_seq: ok.
    - seqno==exp_seq-1 (mod 256): dup_count++.
    - otherwise: gap_count++.
  - RUN, writeCount check: writeCount!=exp_wc increments wc_err_count.
  - RUN, update: exp_seq<=seqno+1 and exp_wc<=writeCount+1 always (resynchronise on error).
- Arithmetic: 8-bit expectations wrap 255->0 without error (seqno 255 followed by 0 is ok).
- Counters: msg_count increments on every accept. All counters saturate at 2^CNT_W-1 and hold.
- A single accept may increment gap_count or dup_count (never both) and also wc_err_count.

Optional Feature:
- Macro HEARD_SINK_DISPLAY_EN.
- Defined: on each accept in RUN with any error, $display of "HEARDSINK seqno %x exp %x wc %x expwc %x" with the pre-update expected values.
- Undefined: no display code; behaviour and ports otherwise identical.

Decomposition:
- Package heard_pkg:
  - typedef heard_msg_t, a packed struct {v, seqno, writeCount, readCount} parameterised via localparam HEARD_DATA_W=32.
  - typedefs seq_t and cnt_t (logic[7:0] and logic[15:0]).
  - Checker state enum {FIRST, RUN}.
- Sub-module heard_fifo: generic DEPTH-entry FIFO of heard_msg_t with push/pop, full/empty.
- heard_sink instantiates heard_fifo and implements the checker and counters itself.

Test Plan:
- Reset then push seqno 0..5 with writeCount 32..37, out__RDY=1 -> six outputs in order, each one cycle after push; msg_count=6, gap/dup/wc_err=0.
- out__RDY=0, push 5 messages -> heard__RDY drops after the 4th accept. Then raise out__RDY one cycle -> one pop; heard__RDY returns next cycle; 5th message accepted.
- seqno 10,11,13,13,14 with matching writeCount -> gap_count=1, dup_count=1, msg_count=5.
- seqno 254,255,0,1 with writeCount 0xFE,0xFF,0x00,0x01 -> no errors (wrap).
- writeCount 40,41,43 with consecutive seqno -> wc_err_count=1 only.
- Hold FIFO at 3 entries, assert nRST=0 one cycle -> out__ENA=0, heard__RDY=1, counters 0; next message is treated as FIRST and no error is counted.
